proc_run_monitor: RTL and testbench

Synthesizable on-chip run monitor for the single-cycle processor. On `start` it resets the processor, then runs the program through up to `NUM_CHECKS` program checkpoints. At each checkpoint it samples `dMemOut` against an expected value and tallies passes. A watchdog aborts runaway programs. It sits beside `SingleCycleProc`, driving its reset and observing `currentPC`/`dMemOut`, so regression results are produced in hardware rather than only by a bench.

---
 rtl/proc_mon_pkg.sv | 16 +
 rtl/proc_run_monitor_watchdog.sv | 32 +++
 rtl/proc_run_monitor.sv | 127 ++++++++++++
 tb/tb_proc_run_monitor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_mon_pkg.sv
// Shared types and defaults for the processor run monitor.
package proc_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRST,
        RUN,
        SETTLE,
        DONE,
        TIMEOUT
    } mon_state_t;

    localparam int unsigned DEF_WDOG_W     = 16;
    localparam int unsigned DEF_WDOG_LIMIT = 'h1FF;

endpackage

// File: rtl/proc_run_monitor_watchdog.sv
// Run watchdog: counts active cycles since the last clear.
module run_watchdog
    import proc_mon_pkg::*;
#(
    parameter int unsigned WDOG_W     = DEF_WDOG_W,
    parameter int unsigned WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WDOG_W-1:0] PRE_LIMIT = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the cycle whose closing edge brings the count to the limit.
    assign expired = enable && (count == PRE_LIMIT);

endmodule

// File: rtl/proc_run_monitor.sv
// On-chip run monitor: resets the processor, samples checkpoints, tallies passes.
module proc_run_monitor
    import proc_mon_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned NUM_CHECKS = 2,
    parameter int unsigned RST_CYCLES = 1,
    parameter int unsigned WDOG_W     = DEF_WDOG_W,
    parameter int unsigned WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic                               CLK,
    input  logic                               Reset,
    input  logic                               start,
    input  logic [ADDR_W-1:0]                  currentPC,
    input  logic [DATA_W-1:0]                  dMemOut,
    input  logic [NUM_CHECKS*ADDR_W-1:0]       chkPC,
    input  logic [NUM_CHECKS*DATA_W-1:0]       chkVal,
    output logic                               procReset_L,
    output logic                               busy,
    output logic                               done,
    output logic                               timeout,
    output logic [NUM_CHECKS-1:0]              passVec,
    output logic [$clog2(NUM_CHECKS+1)-1:0]    passCount,
    output logic                               allPassed
);

    localparam int unsigned CNT_W = $clog2(NUM_CHECKS + 1);
    localparam int unsigned IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int unsigned RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
    localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALL_CNT  = CNT_W'(NUM_CHECKS);

    mon_state_t        state;
    mon_state_t        next_state;
    logic [IDX_W-1:0]  idx;
    logic [RC_W-1:0]   rst_cnt;
    logic [ADDR_W-1:0] cur_pc;
    logic [DATA_W-1:0] cur_val;
    logic              active;
    logic              launch;
    logic              last;
    logic              hit;
    logic              match;
    logic              expired;

    assign cur_pc  = chkPC[int'(idx)*ADDR_W +: ADDR_W];
    assign cur_val = chkVal[int'(idx)*DATA_W +: DATA_W];
    assign active  = state inside {PRST, RUN, SETTLE};
    assign launch  = start && !active;
    assign last    = (idx == LAST_IDX);
    assign hit     = (currentPC >= cur_pc);
    assign match   = (dMemOut == cur_val);

    run_watchdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .CLK     (CLK),
        .Reset   (Reset),
        .clear   (launch),
        .enable  (active),
        .expired (expired)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE, TIMEOUT: if (start) next_state = PRST;
            PRST:                if (rst_cnt == LAST_RC) next_state = RUN;
            RUN: begin
                if (expired)  next_state = TIMEOUT;
                else if (hit) next_state = SETTLE;
            end
            // The last sample wins over a watchdog expiring on the same edge.
            SETTLE: begin
                if (last)         next_state = DONE;
                else if (expired) next_state = TIMEOUT;
                else              next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            procReset_L <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            passVec     <= '0;
            passCount   <= '0;
            idx         <= '0;
            rst_cnt     <= '0;
        end else begin
            state       <= next_state;
            procReset_L <= (next_state != PRST);
            busy        <= next_state inside {PRST, RUN, SETTLE};
            done        <= next_state inside {DONE, TIMEOUT};
            timeout     <= (next_state == TIMEOUT);
            if (launch) begin
                passVec   <= '0;
                passCount <= '0;
                idx       <= '0;
                rst_cnt   <= '0;
            end
            if (state == PRST) begin
                rst_cnt <= rst_cnt + 1'b1;
            end
            if (state == SETTLE) begin
                if (match) begin
                    passVec[idx] <= 1'b1;
                    passCount    <= passCount + 1'b1;
                end
                if (!last) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign allPassed = done && !timeout && (passCount == ALL_CNT);

endmodule

// File: tb/tb_proc_run_monitor.sv
// Randomised self-checking bench for proc_run_monitor against a trace-walking model.
module tb_proc_run_monitor;

    localparam int N   = 2;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int RST = 1;
    localparam int LIM = 'h1FF;
    localparam int TL  = 600;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] currentPC = '0;
    logic [DW-1:0] dMemOut = '0;
    logic [N*AW-1:0] chkPC = '0;
    logic [N*DW-1:0] chkVal = '0;
    logic          procReset_L;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [N-1:0]  passVec;
    logic [1:0]    passCount;
    logic          allPassed;

    always #5 CLK = ~CLK;

    proc_run_monitor #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .NUM_CHECKS (N),
        .RST_CYCLES (RST),
        .WDOG_W     (16),
        .WDOG_LIMIT (LIM)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .start       (start),
        .currentPC   (currentPC),
        .dMemOut     (dMemOut),
        .chkPC       (chkPC),
        .chkVal      (chkVal),
        .procReset_L (procReset_L),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .passVec     (passVec),
        .passCount   (passCount),
        .allPassed   (allPassed)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Trace index k = value presented in the cycle closing with edge start+k.
    logic [63:0] pc_tr [TL];
    logic [63:0] dm_tr [TL];
    logic [63:0] cpc [N];
    logic [63:0] cval [N];

    int m_done;
    bit m_to;
    int m_smp [N];
    bit m_pass [N];

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walk the traces edge by edge after the start edge.
    function automatic void model();
        int e;
        m_to = 1'b0;
        m_done = 0;
        for (int i = 0; i < N; i++) begin
            m_smp[i] = -1;
            m_pass[i] = 1'b0;
        end
        e = RST;
        for (int i = 0; i < N; i++) begin
            e++;
            while (1) begin
                if (e == LIM) begin
                    m_to = 1'b1;
                    m_done = e;
                    return;
                end
                if (pc_tr[e] >= cpc[i]) break;
                e++;
            end
            e++;
            m_smp[i] = e;
            m_pass[i] = (dm_tr[e] == cval[i]);
            if (i == N - 1) begin
                m_done = e;
                return;
            end
            if (e == LIM) begin
                m_to = 1'b1;
                m_done = e;
                return;
            end
        end
    endfunction

    function automatic void gen_ramp(input int stall_from, input int stall_to);
        logic [63:0] pc = '0;
        for (int k = 0; k < TL; k++) begin
            pc_tr[k] = pc;
            if (k > RST && !(k >= stall_from && k < stall_to)) pc += 64'd4;
        end
    endfunction

    function automatic void fill_dm(input logic [63:0] th0, input logic [63:0] th1,
                                    input logic [63:0] v0, input logic [63:0] v1);
        for (int k = 0; k < TL; k++) begin
            if (pc_tr[k] >= th1)      dm_tr[k] = v1;
            else if (pc_tr[k] >= th0) dm_tr[k] = v0;
            else                      dm_tr[k] = 64'h0;
        end
    endfunction

    task automatic check_cycle(input string name, input int j);
        logic [1:0] epv = '0;
        int epc = 0;
        for (int i = 0; i < N; i++) begin
            if (m_smp[i] >= 0 && m_smp[i] <= j && m_pass[i]) begin
                epv[i] = 1'b1;
                epc++;
            end
        end
        check_eq($sformatf("%s.procReset_L@%0d", name, j), 64'(procReset_L), 64'(j >= RST));
        check_eq($sformatf("%s.busy@%0d", name, j), 64'(busy), 64'(j < m_done));
        check_eq($sformatf("%s.done@%0d", name, j), 64'(done), 64'(j >= m_done));
        check_eq($sformatf("%s.timeout@%0d", name, j), 64'(timeout),
                 64'(j >= m_done && m_to));
        check_eq($sformatf("%s.passVec@%0d", name, j), 64'(passVec), 64'(epv));
        check_eq($sformatf("%s.passCount@%0d", name, j), 64'(passCount), 64'(epc));
        check_eq($sformatf("%s.allPassed@%0d", name, j), 64'(allPassed),
                 64'(j >= m_done && !m_to && epc == N));
    endtask

    task automatic check_reset_vals(input string name);
        check_eq({name, ".procReset_L"}, 64'(procReset_L), 64'(0));
        check_eq({name, ".busy"}, 64'(busy), 64'(0));
        check_eq({name, ".done"}, 64'(done), 64'(0));
        check_eq({name, ".timeout"}, 64'(timeout), 64'(0));
        check_eq({name, ".passVec"}, 64'(passVec), 64'(0));
        check_eq({name, ".passCount"}, 64'(passCount), 64'(0));
        check_eq({name, ".allPassed"}, 64'(allPassed), 64'(0));
    endtask

    task automatic run(input string name, input int abort_at, input int restart_at);
        model();
        chkPC  = {cpc[1], cpc[0]};
        chkVal = {cval[1], cval[0]};
        currentPC = pc_tr[0];
        dMemOut   = dm_tr[0];
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        for (int j = 0; j <= m_done; j++) begin
            check_cycle(name, j);
            if (j == abort_at) begin
                Reset = 1'b1;
                #1;
                check_reset_vals({name, ".async"});
                #2;
                Reset = 1'b0;
                @(posedge CLK);
                #1;
                check_eq({name, ".idle_procReset_L"}, 64'(procReset_L), 64'(1));
                check_eq({name, ".idle_busy"}, 64'(busy), 64'(0));
                return;
            end
            if (j < m_done) begin
                currentPC = pc_tr[j+1];
                dMemOut   = dm_tr[j+1];
                start     = (j + 1 == restart_at);
                @(posedge CLK);
                #1;
                start = 1'b0;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] big;
        logic [63:0] pc;
        big = 64'h123456789ABCDEF0;

        #1 Reset = 1'b1;
        #1;
        check_reset_vals("reset");
        repeat (2) @(posedge CLK);
        #1;
        check_reset_vals("reset_hold");
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("idle.procReset_L", 64'(procReset_L), 64'(1));
        check_eq("idle.busy", 64'(busy), 64'(0));

        cpc[0] = 64'h30; cpc[1] = 64'h64;
        cval[0] = 64'hF; cval[1] = big;
        gen_ramp(0, 0);
        fill_dm(64'h30, 64'h64, 64'hF, big);
        run("pass", -1, 0);
        check_eq("pass.final_vec", 64'(passVec), 64'(3));

        cval[1] = 64'h0;
        run("mism1", -1, 0);
        cval[1] = big;

        for (int k = 0; k < TL; k++) pc_tr[k] = 64'h10;
        fill_dm(64'h30, 64'h64, 64'hF, big);
        run("stuck", -1, 0);

        gen_ramp(0, 0);
        fill_dm(64'h30, 64'h64, 64'hF, big);
        model();
        run("abort", m_smp[0] + 1, 0);
        run("after_abort", -1, 0);
        run("restart_ign", -1, 10);
        run("from_done", -1, 0);

        for (int k = 0; k < TL; k++) begin
            if (k < 2)        pc_tr[k] = 64'h0;
            else if (k < 510) pc_tr[k] = (4 * (k - 2) < 64'h40) ? 64'(4 * (k - 2)) : 64'h40;
            else              pc_tr[k] = 64'h64 + 64'(4 * (k - 510));
        end
        fill_dm(64'h30, 64'h64, 64'hF, big);
        run("wd_last", -1, 0);
        cpc[0] = 64'h64; cpc[1] = 64'h100;
        cval[0] = big;
        run("wd_mid", -1, 0);

        for (int r = 0; r < 24; r++) begin
            bit stuck;
            int k_s;
            logic [63:0] v0;
            logic [63:0] v1;
            cpc[0]  = 64'(4 * $urandom_range(1, 40));
            cpc[1]  = cpc[0] + 64'(4 * $urandom_range(0, 30));
            cval[0] = {$urandom, $urandom};
            cval[1] = {$urandom, $urandom};
            v0 = ($urandom % 4 != 0) ? cval[0] : {$urandom, $urandom};
            v1 = ($urandom % 4 != 0) ? cval[1] : {$urandom, $urandom};
            stuck = ($urandom % 6 == 0);
            k_s = $urandom_range(3, 60);
            pc = '0;
            for (int k = 0; k < TL; k++) begin
                pc_tr[k] = pc;
                if (k > RST && !(stuck && k >= k_s) && ($urandom % 4 != 0)) pc += 64'd4;
            end
            fill_dm(cpc[0], cpc[1], v0, v1);
            run($sformatf("rnd%0d", r), -1,
                ($urandom % 3 == 0) ? int'($urandom_range(1, 60)) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
